arith_monitor: RTL and testbench

- Receiving end of the stimulus path. Takes the delayed operand copies that the driver produces, plus the DUT result.
- Computes the golden result and aligns it to the DUT pipeline latency with an internal delay line.
- Compares each golden result with the DUT result and keeps pass/fail statistics.
- Captures the first mismatching transaction.
- Runs a small run-control FSM: idle, run, halt on failure, done after N checks.

---
 rtl/arith_monitor.sv | 142 ++++++++++++++
 tb/tb_arith_monitor.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arith_monitor.sv
// Receiving end of the stimulus path: aligns a golden result to the DUT latency,
// compares it with the DUT result, keeps saturating statistics and captures the first mismatch.
module arith_monitor #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned LATENCY      = 2,
    parameter int unsigned OP           = 0,
    parameter int unsigned NUM_TESTS    = 1000,
    parameter int unsigned STOP_ON_FAIL = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic             i_clear,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_drive_delayed_a,
    input  logic [WIDTH-1:0] i_drive_delayed_b,
    input  logic [WIDTH-1:0] i_result,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_halted,
    output logic             o_error,
    output logic [WIDTH-1:0] o_pass_count,
    output logic [WIDTH-1:0] o_fail_count,
    output logic [WIDTH-1:0] o_fail_a,
    output logic [WIDTH-1:0] o_fail_b,
    output logic [WIDTH-1:0] o_fail_expected,
    output logic [WIDTH-1:0] o_fail_got
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] golden;
    logic             dl_vld_q [LATENCY];
    logic [WIDTH-1:0] dl_a_q   [LATENCY];
    logic [WIDTH-1:0] dl_b_q   [LATENCY];
    logic [WIDTH-1:0] dl_g_q   [LATENCY];
    logic [WIDTH-1:0] pass_q, pass_d, fail_q, fail_d;
    logic [WIDTH-1:0] fail_a_q, fail_b_q, fail_exp_q, fail_got_q;
    logic             error_q;
    logic             check, do_pass, do_fail, last_check;
    logic [WIDTH:0]   checked_d;

    always_comb begin
        case (OP)
            1:       golden = i_drive_delayed_a - i_drive_delayed_b;
            2:       golden = i_drive_delayed_a * i_drive_delayed_b;
            default: golden = i_drive_delayed_a + i_drive_delayed_b;
        endcase
    end

    // Only the head of the delay line is checked, and only while running.
    always_comb begin
        check   = dl_vld_q[LATENCY-1] && (state_q == S_RUN);
        do_pass = check && (dl_g_q[LATENCY-1] == i_result);
        do_fail = check && (dl_g_q[LATENCY-1] != i_result);
        pass_d  = pass_q;
        fail_d  = fail_q;
        if (do_pass && (pass_q != '1)) pass_d = pass_q + WIDTH'(1);
        if (do_fail && (fail_q != '1)) fail_d = fail_q + WIDTH'(1);
        checked_d  = {1'b0, pass_d} + {1'b0, fail_d};
        last_check = check && (NUM_TESTS != 0) && (checked_d == (WIDTH+1)'(NUM_TESTS));
    end

    always_ff @(posedge clk) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (i_start) state_d = S_RUN;
            S_RUN: begin
                if (do_fail && (STOP_ON_FAIL != 0)) state_d = S_HALT;
                else if (last_check)                state_d = S_DONE;
            end
            default: state_d = state_q;
        endcase
        if (i_clear) state_d = S_IDLE;
    end

    always_comb begin
        o_busy   = (state_q == S_RUN);
        o_done   = (state_q == S_DONE);
        o_halted = (state_q == S_HALT);
    end

    always_ff @(posedge clk) begin
        if (!reset || i_clear) begin
            for (int unsigned i = 0; i < LATENCY; i++) dl_vld_q[i] <= 1'b0;
        end else begin
            dl_vld_q[0] <= (state_q == S_RUN) && i_valid;
            for (int unsigned i = 1; i < LATENCY; i++) dl_vld_q[i] <= dl_vld_q[i-1];
        end
    end

    // Payload needs no reset: it is only ever qualified by the valid bits.
    always_ff @(posedge clk) begin
        dl_a_q[0] <= i_drive_delayed_a;
        dl_b_q[0] <= i_drive_delayed_b;
        dl_g_q[0] <= golden;
        for (int unsigned i = 1; i < LATENCY; i++) begin
            dl_a_q[i] <= dl_a_q[i-1];
            dl_b_q[i] <= dl_b_q[i-1];
            dl_g_q[i] <= dl_g_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || i_clear) begin
            pass_q     <= '0;
            fail_q     <= '0;
            error_q    <= 1'b0;
            fail_a_q   <= '0;
            fail_b_q   <= '0;
            fail_exp_q <= '0;
            fail_got_q <= '0;
        end else begin
            pass_q <= pass_d;
            fail_q <= fail_d;
            if (do_fail) begin
                error_q <= 1'b1;
                if (fail_q == '0) begin
                    fail_a_q   <= dl_a_q[LATENCY-1];
                    fail_b_q   <= dl_b_q[LATENCY-1];
                    fail_exp_q <= dl_g_q[LATENCY-1];
                    fail_got_q <= i_result;
                end
            end
        end
    end

    assign o_error         = error_q;
    assign o_pass_count    = pass_q;
    assign o_fail_count    = fail_q;
    assign o_fail_a        = fail_a_q;
    assign o_fail_b        = fail_b_q;
    assign o_fail_expected = fail_exp_q;
    assign o_fail_got      = fail_got_q;

endmodule

// File: tb/tb_arith_monitor.sv
// Bench for arith_monitor: six configurations share one stimulus stream; a bench-side
// DUT model produces i_result per latency, with per-instance error injection.
module tb_arith_monitor;

    localparam int NDUT = 6;
    localparam int unsigned LATS  [NDUT] = '{2, 2, 2, 2, 1, 16};
    localparam int unsigned OPS   [NDUT] = '{0, 0, 1, 2, 0, 0};
    localparam int unsigned NUMS  [NDUT] = '{4, 4, 0, 0, 0, 0};
    localparam int unsigned STOPS [NDUT] = '{1, 0, 1, 1, 1, 1};

    typedef struct {
        logic [31:0] a, b, sum, diff, prod;
    } vec_t;

    logic            clk = 1'b0;
    logic            reset, i_start, i_clear, i_valid;
    logic [31:0]     in_a, in_b;
    logic [NDUT-1:0] err;

    logic [31:0]     pa [16];
    logic [31:0]     pb [16];
    logic [NDUT-1:0] pe [16];

    logic [31:0] res [NDUT];
    logic        busy [NDUT];
    logic        done [NDUT];
    logic        halted [NDUT];
    logic        error [NDUT];
    logic [31:0] pass_c [NDUT];
    logic [31:0] fail_c [NDUT];
    logic [31:0] fa [NDUT];
    logic [31:0] fb [NDUT];
    logic [31:0] fe [NDUT];
    logic [31:0] fg [NDUT];

    int unsigned cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    bit          mon_en = 1'b0;
    bit          sb_en = 1'b0;
    logic [31:0] prev4, prev5;
    int unsigned sb4 [$];
    int unsigned sb5 [$];
    vec_t        vecs [6];

    function automatic logic [31:0] ref_op(input int unsigned op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            1:       return a - b;
            2:       return a * b;
            default: return a + b;
        endcase
    endfunction

    always #5 clk = ~clk;

    // Bench copy of the operand stream; the model result for latency L reads stage L-1.
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        pa[0] <= in_a;
        pb[0] <= in_b;
        pe[0] <= err;
        for (int i = 1; i < 16; i++) begin
            pa[i] <= pa[i-1];
            pb[i] <= pb[i-1];
            pe[i] <= pe[i-1];
        end
    end

    for (genvar g = 0; g < NDUT; g++) begin : gen_dut
        assign res[g] = ref_op(OPS[g], pa[LATS[g]-1], pb[LATS[g]-1]) + 32'(pe[LATS[g]-1][g]);

        arith_monitor #(
            .WIDTH       (32),
            .LATENCY     (LATS[g]),
            .OP          (OPS[g]),
            .NUM_TESTS   (NUMS[g]),
            .STOP_ON_FAIL(STOPS[g])
        ) u_dut (
            .clk              (clk),
            .reset            (reset),
            .i_start          (i_start),
            .i_clear          (i_clear),
            .i_valid          (i_valid),
            .i_drive_delayed_a(in_a),
            .i_drive_delayed_b(in_b),
            .i_result         (res[g]),
            .o_busy           (busy[g]),
            .o_done           (done[g]),
            .o_halted         (halted[g]),
            .o_error          (error[g]),
            .o_pass_count     (pass_c[g]),
            .o_fail_count     (fail_c[g]),
            .o_fail_a         (fa[g]),
            .o_fail_b         (fb[g]),
            .o_fail_expected  (fe[g]),
            .o_fail_got       (fg[g])
        );
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_zero(input string tag, input int k);
        chk({tag, "_busy"},   32'(busy[k]),   32'd0);
        chk({tag, "_done"},   32'(done[k]),   32'd0);
        chk({tag, "_halted"}, 32'(halted[k]), 32'd0);
        chk({tag, "_error"},  32'(error[k]),  32'd0);
        chk({tag, "_pass"},   pass_c[k],      32'd0);
        chk({tag, "_fail"},   fail_c[k],      32'd0);
        chk({tag, "_fa"},     fa[k],          32'd0);
        chk({tag, "_fb"},     fb[k],          32'd0);
        chk({tag, "_fexp"},   fe[k],          32'd0);
        chk({tag, "_fgot"},   fg[k],          32'd0);
    endtask

    // Inputs change right after a falling edge; the expected arrival cycle of each check is queued.
    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [NDUT-1:0] e);
        i_valid = v;
        in_a    = a;
        in_b    = b;
        err     = e;
        if (v && sb_en) begin
            sb4.push_back(cyc + 1 + LATS[4]);
            sb5.push_back(cyc + 1 + LATS[5]);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, $urandom, $urandom, '0);
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        idle(1);
        i_start = 1'b0;
    endtask

    task automatic pulse_clear();
        i_clear = 1'b1;
        idle(1);
        i_clear = 1'b0;
    endtask

    always @(negedge clk) begin : scoreboard
        int unsigned exp_c;
        if (mon_en) begin
            if (pass_c[4] != prev4) begin
                chk("lat1_step", pass_c[4], prev4 + 32'd1);
                exp_c = (sb4.size() != 0) ? sb4.pop_front() : 0;
                chk("lat1_arrival", cyc, exp_c);
                prev4 = pass_c[4];
            end
            if (pass_c[5] != prev5) begin
                chk("lat16_step", pass_c[5], prev5 + 32'd1);
                exp_c = (sb5.size() != 0) ? sb5.pop_front() : 0;
                chk("lat16_arrival", cyc, exp_c);
                prev5 = pass_c[5];
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{32'd3,          32'd5,          32'd8,          32'hFFFF_FFFE, 32'd15};
        vecs[1] = '{32'hFFFF_FFFF, 32'd1,          32'd0,          32'hFFFF_FFFE, 32'hFFFF_FFFF};
        vecs[2] = '{32'd0,          32'd1,          32'd1,          32'hFFFF_FFFF, 32'd0};
        vecs[3] = '{32'h0001_0000, 32'h0001_0000, 32'h0002_0000, 32'd0,          32'd0};
        vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd0,          32'd1};
        vecs[5] = '{32'h1234_5678, 32'h0000_0100, 32'h1234_5778, 32'h1234_5578, 32'h3456_7800};

        reset = 1'b0; i_start = 1'b0; i_clear = 1'b0; i_valid = 1'b0;
        in_a = '0; in_b = '0; err = '0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < NDUT; k++) chk_zero($sformatf("reset%0d", k), k);
        reset = 1'b1;
        idle(1);

        // All four pairs correct, including the wrapping sum.
        pulse_start();
        chk("t1_busy", 32'(busy[0]), 32'd1);
        drive(1'b1, 32'd1, 32'd2, '0);
        drive(1'b1, 32'hFFFF_FFFF, 32'd1, '0);
        drive(1'b1, 32'd5, 32'd7, '0);
        drive(1'b1, 32'd10, 32'd20, '0);
        chk("t1_pass_mid", pass_c[0], 32'd2);
        idle(1);
        chk("t1_done_early", 32'(done[0]), 32'd0);
        chk("t1_pass_3", pass_c[0], 32'd3);
        idle(1);
        chk("t1_done", 32'(done[0]), 32'd1);
        chk("t1_busy_off", 32'(busy[0]), 32'd0);
        chk("t1_pass", pass_c[0], 32'd4);
        chk("t1_fail", fail_c[0], 32'd0);
        chk("t1_error", 32'(error[0]), 32'd0);

        // Stop-on-fail (inst 0, error on pair 3) and keep-running (inst 1, errors on pairs 1 and 3).
        pulse_clear();
        chk("t2_cleared_done", 32'(done[0]), 32'd0);
        pulse_start();
        drive(1'b1, 32'd1, 32'd2, 6'b000010);
        drive(1'b1, 32'hFFFF_FFFF, 32'd1, '0);
        drive(1'b1, 32'd5, 32'd7, 6'b000011);
        drive(1'b1, 32'd10, 32'd20, '0);
        idle(4);
        chk("t2_pass", pass_c[0], 32'd2);
        chk("t2_fail", fail_c[0], 32'd1);
        chk("t2_halted", 32'(halted[0]), 32'd1);
        chk("t2_done", 32'(done[0]), 32'd0);
        chk("t2_error", 32'(error[0]), 32'd1);
        chk("t2_fa", fa[0], 32'd5);
        chk("t2_fb", fb[0], 32'd7);
        chk("t2_fexp", fe[0], 32'd12);
        chk("t2_fgot", fg[0], 32'd13);
        chk("t3_pass", pass_c[1], 32'd2);
        chk("t3_fail", fail_c[1], 32'd2);
        chk("t3_done", 32'(done[1]), 32'd1);
        chk("t3_halted", 32'(halted[1]), 32'd0);
        chk("t3_fa", fa[1], 32'd1);
        chk("t3_fb", fb[1], 32'd2);
        chk("t3_fexp", fe[1], 32'd3);
        chk("t3_fgot", fg[1], 32'd4);

        // Golden values of all three operations, exposed through the mismatch capture.
        for (int r = 0; r < 6; r++) begin
            pulse_clear();
            pulse_start();
            drive(1'b1, vecs[r].a, vecs[r].b, 6'b001101);
            idle(3);
            chk($sformatf("vec%0d_add", r), fe[0], vecs[r].sum);
            chk($sformatf("vec%0d_add_got", r), fg[0], vecs[r].sum + 32'd1);
            chk($sformatf("vec%0d_sub", r), fe[2], vecs[r].diff);
            chk($sformatf("vec%0d_mul", r), fe[3], vecs[r].prod);
            chk($sformatf("vec%0d_halt", r), 32'(halted[3]), 32'd1);
        end

        // Gapped valids: 1,0,0,1,1 with junk operands in the gaps.
        pulse_clear();
        pulse_start();
        drive(1'b1, 32'd3, 32'd5, '0);
        idle(2);
        drive(1'b1, 32'd9, 32'd2, '0);
        drive(1'b1, 32'd100, 32'd7, '0);
        idle(4);
        chk("t4_sub_pass", pass_c[2], 32'd3);
        chk("t4_sub_fail", fail_c[2], 32'd0);
        chk("t4_mul_pass", pass_c[3], 32'd3);
        chk("t4_mul_fail", fail_c[3], 32'd0);

        // Clear with entries in flight: nothing may be checked afterwards.
        pulse_clear();
        pulse_start();
        drive(1'b1, 32'd1, 32'd1, '1);
        drive(1'b1, 32'd2, 32'd2, '1);
        pulse_clear();
        chk_zero("t5_clr0", 0);
        chk_zero("t5_clr4", 4);
        chk_zero("t5_clr5", 5);
        pulse_start();
        idle(20);
        chk("t5_clr_fail16", fail_c[5], 32'd0);
        chk("t5_clr_pass16", pass_c[5], 32'd0);
        chk("t5_clr_fail2", fail_c[0], 32'd0);

        // Same with reset.
        drive(1'b1, 32'd1, 32'd1, '1);
        drive(1'b1, 32'd2, 32'd2, '1);
        reset = 1'b0;
        idle(1);
        reset = 1'b1;
        chk_zero("t5_rst0", 0);
        chk_zero("t5_rst5", 5);
        pulse_start();
        idle(20);
        chk("t5_rst_fail16", fail_c[5], 32'd0);
        chk("t5_rst_pass16", pass_c[5], 32'd0);

        // Valids before start are not captured.
        pulse_clear();
        for (int i = 0; i < 3; i++) drive(1'b1, 32'(i), 32'd4, '1);
        pulse_start();
        idle(20);
        chk("t5_pre_busy", 32'(busy[0]), 32'd1);
        chk("t5_pre_pass2", pass_c[0] + fail_c[0], 32'd0);
        chk("t5_pre_pass16", pass_c[5] + fail_c[5], 32'd0);

        // 20 back-to-back valids on latency 1 and 16, arrival cycles tracked by the scoreboard.
        pulse_clear();
        pulse_start();
        prev4  = pass_c[4];
        prev5  = pass_c[5];
        sb_en  = 1'b1;
        mon_en = 1'b1;
        for (int i = 0; i < 20; i++) drive(1'b1, $urandom, $urandom, '0);
        sb_en = 1'b0;
        idle(20);
        mon_en = 1'b0;
        chk("t6_lat1_pass", pass_c[4], 32'd20);
        chk("t6_lat1_fail", fail_c[4], 32'd0);
        chk("t6_lat16_pass", pass_c[5], 32'd20);
        chk("t6_lat16_fail", fail_c[5], 32'd0);
        chk("t6_sb4_left", 32'(sb4.size()), 32'd0);
        chk("t6_sb5_left", 32'(sb5.size()), 32'd0);

        // Saturation of the pass counter.
        force gen_dut[4].u_dut.pass_q = 32'hFFFF_FFFE;
        idle(2);
        release gen_dut[4].u_dut.pass_q;
        chk("t6_sat_preload", pass_c[4], 32'hFFFF_FFFE);
        for (int i = 0; i < 3; i++) drive(1'b1, $urandom, $urandom, '0);
        idle(2);
        chk("t6_sat_pass", pass_c[4], 32'hFFFF_FFFF);
        chk("t6_sat_fail", fail_c[4], 32'd0);
        chk("t6_sat_busy", 32'(busy[4]), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
